// File: rtl/ofdm_pkg.sv
// Shared definitions for the OFDM subcarrier-reorder path: order-select
// encodings and the index bit-reversal helper.
package ofdm_pkg;

  localparam logic [1:0] MODE_NAT  = 2'd0;
  localparam logic [1:0] MODE_MIR  = 2'd1;
  localparam logic [1:0] MODE_BREV = 2'd2;

  // Widest index supported (N_SC up to 1024).
  localparam int MAX_AW = 10;

  // Reverse the low aw bits of v; bits at and above aw must be zero on entry.
  function automatic logic [MAX_AW-1:0] bit_rev(input logic [MAX_AW-1:0] v,
                                                input int aw);
    logic [MAX_AW-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_AW; i++) r[i] = v[MAX_AW-1-i];
    return r >> (MAX_AW - aw);
  endfunction

endpackage

// File: rtl/ofdm_reorder_addr.sv
// Combinational permutation address generator: maps an output position to
// the natural-order source index for the selected subcarrier order.
module ofdm_reorder_addr
  import ofdm_pkg::*;
#(
  parameter int AW = 6
) (
  input  logic [AW-1:0] i_cnt,
  input  logic [1:0]    i_mode,
  output logic [AW-1:0] o_addr
);

  logic [MAX_AW-1:0] w_cnt_ext;
  logic [MAX_AW-1:0] w_rev;

  assign w_cnt_ext = MAX_AW'(i_cnt);
  assign w_rev     = bit_rev(w_cnt_ext, AW);

  // NOTE: assign a default before the case so no path leaves o_addr unassigned (no latch).
  always_comb begin
    o_addr = i_cnt;
    case (i_mode)
      // N_SC is 2**AW, so (N_SC - k) mod N_SC is plain AW-bit negation.
      MODE_MIR:  o_addr = {AW{1'b0}} - i_cnt;
      MODE_BREV: o_addr = w_rev[AW-1:0];
      default:   o_addr = i_cnt;
    endcase
  end

endmodule

// File: rtl/ofdm_symbol_reorder.sv
// Ping-pong subcarrier reorder buffer: writes symbols in natural order and
// emits each one in natural, mirror or bit-reversed order.
module ofdm_symbol_reorder
  import ofdm_pkg::*;
#(
  parameter  int N_SC = 64,
  parameter  int W    = 32,
  localparam int AW   = $clog2(N_SC)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [1:0]    mode,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  in_re,
  input  logic [W-1:0]  in_im,
  input  logic          in_last,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [W-1:0]  out_re,
  output logic [W-1:0]  out_im,
  output logic [AW-1:0] out_idx,
  output logic          out_last,
  output logic          frame_err
);

  localparam logic [AW-1:0] LAST_IDX = AW'(N_SC - 1);

  // Two banks of N_SC samples, addressed as {bank, index}.
  logic [2*W-1:0]   r_mem [2*N_SC];

  logic [1:0]       r_full;
  logic [1:0][1:0]  r_tag;
  logic             r_wr_bank;
  logic [AW-1:0]    r_wr_cnt;
  logic             r_rd_bank;
  logic [AW-1:0]    r_rd_cnt;

  logic             r_in_ready;
  logic             r_out_valid;
  logic [W-1:0]     r_out_re;
  logic [W-1:0]     r_out_im;
  logic [AW-1:0]    r_out_idx;
  logic             r_out_last;
  logic             r_frame_err;

  logic             w_accept;
  logic             w_wr_first;
  logic             w_wr_done;
  logic             w_load;
  logic             w_rd_done;
  logic             w_wr_bank_nxt;
  logic [1:0]       w_full_nxt;
  logic [AW-1:0]    w_rd_addr;
  logic [2*W-1:0]   w_rd_data;

  assign w_accept      = in_valid && r_in_ready;
  assign w_wr_first    = (r_wr_cnt == '0);
  assign w_wr_done     = w_accept && (r_wr_cnt == LAST_IDX);
  assign w_load        = r_full[r_rd_bank] && (!r_out_valid || out_ready);
  assign w_rd_done     = w_load && (r_rd_cnt == LAST_IDX);
  assign w_wr_bank_nxt = r_wr_bank ^ w_wr_done;

  ofdm_reorder_addr #(
    .AW (AW)
  ) u_addr (
    .i_cnt  (r_rd_cnt),
    .i_mode (r_tag[r_rd_bank]),
    .o_addr (w_rd_addr)
  );

  assign w_rd_data = r_mem[{r_rd_bank, w_rd_addr}];

  // Writer only fills a non-full bank and reader only drains a full one, so
  // the set and clear below never target the same bank.
  always_comb begin
    w_full_nxt = r_full;
    if (w_wr_done) w_full_nxt[r_wr_bank] = 1'b1;
    if (w_rd_done) w_full_nxt[r_rd_bank] = 1'b0;
  end

  // NOTE: sample storage has no reset; contents are meaningless until written, and bank state guards every read.
  always_ff @(posedge clk) begin
    if (w_accept) r_mem[{r_wr_bank, r_wr_cnt}] <= {in_re, in_im};
  end

  // NOTE: all state below uses non-blocking assignment so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_full      <= '0;
      r_tag       <= {MODE_NAT, MODE_NAT};
      r_wr_bank   <= 1'b0;
      r_wr_cnt    <= '0;
      r_rd_bank   <= 1'b0;
      r_rd_cnt    <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_out_re    <= '0;
      r_out_im    <= '0;
      r_out_idx   <= '0;
      r_out_last  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      r_full      <= w_full_nxt;
      r_wr_bank   <= w_wr_bank_nxt;
      // Registered from next-state: a bank freed this cycle is visible next cycle.
      r_in_ready  <= !w_full_nxt[w_wr_bank_nxt];
      r_frame_err <= w_accept && (in_last != (r_wr_cnt == LAST_IDX));

      if (w_accept) begin
        if (w_wr_first) r_tag[r_wr_bank] <= mode;
        r_wr_cnt <= w_wr_done ? '0 : r_wr_cnt + AW'(1);
      end

      r_out_valid <= w_load || (r_out_valid && !out_ready);
      if (w_load) begin
        r_out_re   <= w_rd_data[2*W-1:W];
        r_out_im   <= w_rd_data[W-1:0];
        r_out_idx  <= r_rd_cnt;
        r_out_last <= (r_rd_cnt == LAST_IDX);
        r_rd_cnt   <= w_rd_done ? '0 : r_rd_cnt + AW'(1);
        if (w_rd_done) r_rd_bank <= ~r_rd_bank;
      end
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_re    = r_out_re;
  assign out_im    = r_out_im;
  assign out_idx   = r_out_idx;
  assign out_last  = r_out_last;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ofdm_symbol_reorder.sv
// Directed bench for ofdm_symbol_reorder: a scoreboard queue holds expected
// outputs per symbol and a negedge monitor pops and compares them.
module tb_ofdm_symbol_reorder;

  localparam int N    = 64;
  localparam int W    = 32;
  localparam int AW   = 6;

  localparam logic [1:0] M_NAT  = 2'd0;
  localparam logic [1:0] M_MIR  = 2'd1;
  localparam logic [1:0] M_BREV = 2'd2;
  localparam logic [1:0] M_RSVD = 2'd3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_re = '0;
  logic [W-1:0]  in_im = '0;
  logic          in_last = 1'b0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out_re;
  logic [W-1:0]  out_im;
  logic [AW-1:0] out_idx;
  logic          out_last;
  logic          frame_err;

  always #5 clk = ~clk;

  ofdm_symbol_reorder #(
    .N_SC (N),
    .W    (W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_re     (in_re),
    .in_im     (in_im),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .frame_err (frame_err)
  );

  typedef struct packed {
    logic [W-1:0]  re;
    logic [W-1:0]  im;
    logic [AW-1:0] idx;
    logic          last;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          errors = 0;
  int          checks = 0;
  int          fe_count = 0;
  int          gaps = 0;
  int          stall_cyc = 0;
  bit          gap_watch = 0;
  bit          gap_seen = 0;
  bit          prev_stall = 0;
  logic [71:0] prev_out = '0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference permutation: output position k reads natural index perm_model(k).
  function automatic int perm_model(input int k, input logic [1:0] m);
    int r;
    case (m)
      M_MIR:  return (N - k) % N;
      M_BREV: begin
        r = 0;
        for (int b = 0; b < AW; b++)
          if (((k >> b) & 1) != 0) r = r | (1 << (AW - 1 - b));
        return r;
      end
      default: return k;
    endcase
  endfunction

  task automatic push_expected(input logic [1:0] m, input logic [W-1:0] base);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      e.re   = base + W'(perm_model(k, m));
      e.im   = -e.re;
      e.idx  = AW'(k);
      e.last = (k == N - 1);
      exp_q.push_back(e);
    end
  endtask

  // Called just after a rising edge; returns just after the accepting edge.
  task automatic push_sample(input logic [W-1:0] re, input logic last);
    int n;
    bit ok;
    n  = 0;
    ok = 1;
    in_valid = 1'b1;
    in_re    = re;
    in_im    = -re;
    in_last  = last;
    @(negedge clk);
    while (!in_ready) begin
      n++;
      stall_cyc++;
      if (n > 1000) begin
        check("in_ready_timeout", in_ready, 1);
        ok = 0;
        break;
      end
      @(negedge clk);
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  // Mode is switched away after sample 0 to show it only latches at symbol start.
  task automatic send_symbol(input logic [1:0] m, input logic [W-1:0] base, input int bad_last);
    for (int k = 0; k < N; k++) begin
      if (k == 0) mode = m;
      push_sample(base + W'(k), (k == N - 1) || (k == bad_last));
      if (k == 0) mode = m + 2'd1;
    end
    push_expected(m, base);
  endtask

  task automatic wait_drain(input string tag, input int budget);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check(tag, exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Output monitor: scoreboard pop, hold-while-stalled, frame_err and gap tracking.
  always @(negedge clk) begin
    if (!reset) begin
      prev_stall = 0;
    end else begin
      if (frame_err) fe_count++;
      if (prev_stall)
        check("hold", {out_valid, out_re, out_im, out_idx, out_last}, prev_out);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_out", out_valid, 0);
        end else begin
          mon_e = exp_q.pop_front();
          check("out_re", out_re, mon_e.re);
          check("out_im", out_im, mon_e.im);
          check("out_idx", out_idx, mon_e.idx);
          check("out_last", out_last, mon_e.last);
        end
      end
      if (gap_watch) begin
        if (out_valid) gap_seen = 1;
        else if (gap_seen && exp_q.size() != 0) gaps++;
      end
      prev_stall = out_valid && !out_ready;
      prev_out   = {out_valid, out_re, out_im, out_idx, out_last};
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int          stall0;
    int          fe0;
    int          acc;
    bit          got;
    logic [W-1:0] sbase;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_re", out_re, 0);
    check("rst_out_im", out_im, 0);
    check("rst_out_idx", out_idx, 0);
    check("rst_out_last", out_last, 0);
    check("rst_frame_err", frame_err, 0);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("in_ready_rise", in_ready, 1);

    // Mirror order and first-output latency into an empty bank
    out_ready = 1'b1;
    send_symbol(M_MIR, 0, -1);
    check("lat_not_early", out_valid, 0);
    @(posedge clk);
    #1;
    check("lat_valid", out_valid, 1);
    check("lat_idx0", out_idx, 0);
    check("lat_re0", out_re, 0);
    wait_drain("drain_mirror", 200);

    // Bit-reversed order
    send_symbol(M_BREV, 1000, -1);
    wait_drain("drain_brev", 200);

    // Three back-to-back symbols: no input stall, no output gap, no framing errors
    stall0    = stall_cyc;
    fe0       = fe_count;
    gaps      = 0;
    gap_seen  = 0;
    gap_watch = 1;
    send_symbol(M_NAT, 2000, -1);
    send_symbol(M_MIR, 3000, -1);
    send_symbol(M_BREV, 4000, -1);
    wait_drain("drain_b2b", 300);
    gap_watch = 0;
    check("b2b_in_stalls", stall_cyc - stall0, 0);
    check("b2b_out_gaps", gaps, 0);
    check("b2b_frame_err", fe_count - fe0, 0);

    // Output back-pressure for 200 cycles with continuous input
    out_ready = 1'b0;
    mode      = M_MIR;
    sbase     = 10000;
    acc       = 0;
    in_valid  = 1'b1;
    in_re     = sbase;
    in_im     = -sbase;
    in_last   = 1'b0;
    for (int c = 0; c < 200; c++) begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      if (got) begin
        acc++;
        if (acc % N == 0) push_expected(M_MIR, sbase + W'(acc - N));
        in_re   = sbase + W'(acc);
        in_im   = -in_re;
        in_last = (acc % N == N - 1);
      end
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    check("stall_accepts", acc, 2 * N);
    check("stall_in_ready_low", in_ready, 0);
    check("stall_out_valid", out_valid, 1);
    check("stall_out_re_held", out_re, sbase);
    out_ready = 1'b1;
    wait_drain("drain_stall", 400);

    // in_last on sample 10 as well as 63: exactly one framing error, full symbol out
    fe0 = fe_count;
    send_symbol(M_NAT, 20000, 10);
    wait_drain("drain_frame", 200);
    check("frame_err_pulses", fe_count - fe0, 1);

    // Reserved mode behaves as natural
    send_symbol(M_RSVD, 25000, -1);
    wait_drain("drain_rsvd", 200);

    // Reset while symbol 1 drains and symbol 2 is 30 samples in
    send_symbol(M_NAT, 30000, -1);
    for (int k = 0; k < 30; k++) push_sample(40000 + W'(k), 1'b0);
    reset = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_out_idx", out_idx, 0);
    check("midrst_out_re", out_re, 0);
    exp_q.delete();
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_in_ready_rise", in_ready, 1);
    check("midrst_idle", out_valid, 0);
    send_symbol(M_MIR, 50000, -1);
    wait_drain("drain_after_reset", 200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ofdm_symbol_reorder.md
Name: ofdm_symbol_reorder

Overview:
- Streaming, parametrised subcarrier-reorder buffer between the FFT/IFFT core and the channel/quantiser/demapper stages of the OFDM chain.
- Accepts one complex sample per handshake in natural index order and emits each symbol in a runtime-selected permuted order: natural, mirror (k -> (N-k) mod N), or bit-reversed.
- Uses ping-pong double buffering, so one symbol can be written while the previous one is read. This supports continuous back-to-back symbols.

Parameters:
- N_SC, 64, subcarriers per symbol; power of two, 8..1024.
- W, 32, bit width of each real/imag component.
- AW, $clog2(N_SC), index width; derived, not overridden.

Ports:
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-low
- mode  in  2  order select: 0 natural, 1 mirror, 2 bit-reverse, 3 reserved (treated as natural)
- in_valid  in  1  input sample valid
- in_ready  out  1  buffer can accept a sample
- in_re  in  W  real component
- in_im  in  W  imag component
- in_last  in  1  producer marks final sample of symbol
- out_valid  out  1  output sample valid
- out_ready  in  1  consumer accepts sample
- out_re  out  W  real component
- out_im  out  W  imag component
- out_idx  out  AW  output position k within symbol
- out_last  out  1  final sample of output symbol
- frame_err  out  1  one-cycle pulse when in_last disagrees with internal count

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_re=0, out_im=0, out_idx=0, out_last=0, frame_err=0.
  - Both banks empty; write and read pointers at bank 0.
  - Memory contents are don't-care.
  - in_ready rises on the first clk after reset deasserts.
- Write side:
  - A sample is accepted when in_valid && in_ready.
  - Stored at wr_bank[wr_cnt]; wr_cnt increments.
  - The mode is latched into the bank's mode tag on sample 0.
  - At wr_cnt == N_SC-1 accept, the bank is marked full, wr_bank toggles and wr_cnt is set to 0.
  - in_ready = !full[wr_bank].
- Framing:
  - The internal count alone defines symbol boundaries.
  - frame_err pulses the cycle after any accept where in_last != (wr_cnt == N_SC-1). Data is not dropped or padded.
- Read side:
  - Active when full[rd_bank].
  - Source address = perm(rd_cnt, tag[rd_bank]):
    - natural: rd_cnt
    - mirror: (N_SC - rd_cnt) mod N_SC
    - bit-reverse: AW-bit reversal of rd_cnt
  - The output register loads when full[rd_bank] && (!out_valid || out_ready).
    - out_idx = rd_cnt.
    - out_last = (rd_cnt == N_SC-1).
  - After the N_SC-1 load: full[rd_bank] clears, rd_bank toggles, rd_cnt is set to 0.
- Latency: the final input sample accepted at edge t gives out_valid=1 with k=0 after edge t+1, provided that bank was empty.
- Throughput: with out_ready held high, one sample per cycle and no bubble between symbols.
- Output stability: while out_valid && !out_ready, all out_* hold stable.
- Simultaneous events:
  - Write completion and read completion in the same cycle on different banks both take effect.
  - A bank freed this cycle makes in_ready=1 next cycle; there is no same-cycle bypass.
- Mode: changes to mode mid-symbol have no effect until the next sample 0.
- Reset mid-operation: asynchronously discards all partial and full symbols and forces the reset values above.

Decomposition:
- Package ofdm_pkg holds:
  - mode encoding constants MODE_NAT=0, MODE_MIR=1, MODE_BREV=2.
  - a bit-reverse function parametrised by AW.
- One sub-module is natural: ofdm_reorder_addr, a combinational permutation address generator (cnt, mode -> addr), reused by future demapper/pilot-extraction blocks.

Test Plan:
- Mirror mode, N_SC=64, in_re=k, in_im=-k, out_ready=1 → outputs in_re 0,63,62,...,1; out_last on 64th output; first out_valid one cycle after last input.
- Bit-reverse mode, N_SC=8, in_re=k → out_re 0,4,2,6,1,5,3,7; out_idx 0..7.
- Three back-to-back symbols, modes NAT/MIR/BREV, out_ready=1 → in_ready stays 1 until both banks full; correct per-symbol order; no inter-symbol gap.
- out_ready held 0 for 200 cycles with continuous input → in_ready drops after 128 accepts (N_SC=64); out_re held constant; resuming out_ready gives lossless order.
- in_last asserted on sample 10 of symbol → frame_err pulses exactly once; symbol still emitted with 64 samples.
- reset pulsed after 30 samples of symbol 2 while symbol 1 is draining → out_valid=0 immediately; next 64 inputs emerge as a clean symbol with out_idx from 0.
